// File: rtl/ehgu_basic_pkg.sv
// rtl/ehgu_basic_pkg.sv - shared types and the bubble-fix helper for the ehgu thermometer path
// Purpose : sizes, the therm_t/bin_t typedefs and a reference bubble-fix function.
// Ports   : none (package).
package ehgu_basic_pkg;

    localparam int BINARY_OF_THERM_SIZE = 8;
    localparam int THERM_SIZE           = 2**BINARY_OF_THERM_SIZE - 1;

    typedef logic [THERM_SIZE-1:0]           therm_t;
    typedef logic [BINARY_OF_THERM_SIZE-1:0] bin_t;

    typedef struct packed {
        therm_t corr;
        logic   bubble;
    } therm_fix_t;

    // Majority-of-three repair with t[-1]=1 and t[THERM_SIZE]=0; bubble is
    // taken from the raw word, so it reports even bubbles that get repaired.
    function automatic therm_fix_t therm_bubble_fix(input therm_t t);
        therm_fix_t                r;
        logic [THERM_SIZE+1:0]     ext;
        ext      = {1'b0, t, 1'b1};
        r.bubble = 1'b0;
        for (int i = 0; i < THERM_SIZE; i++) begin
            r.corr[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
        end
        for (int i = 0; i < THERM_SIZE-1; i++) begin
            r.bubble = r.bubble | (t[i+1] & ~t[i]);
        end
        return r;
    endfunction

endpackage

// File: rtl/ehgu_therm_bubble_fix.sv
// rtl/ehgu_therm_bubble_fix.sv - combinational single-bit bubble repair for a thermometer word
// Purpose : corr[i] = maj(t[i-1], t[i], t[i+1]) with t[-1]=1, t[W]=0; bubble flags any 0 below a 1.
// Ports   : therm_i  raw thermometer word
//           corr_o   repaired word
//           bubble_o raw word was non-monotonic
module ehgu_therm_bubble_fix
    import ehgu_basic_pkg::*;
#(
    parameter int THERM_W = THERM_SIZE
) (
    input  logic [THERM_W-1:0] therm_i,
    output logic [THERM_W-1:0] corr_o,
    output logic               bubble_o
);

    logic [THERM_W+1:0] ext;

    assign ext = {1'b0, therm_i, 1'b1};

    always_comb begin
        corr_o   = '0;
        bubble_o = 1'b0;
        for (int i = 0; i < THERM_W; i++) begin
            corr_o[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
        end
        // The boundary terms (t[0]&~t[-1], t[W]&~t[W-1]) are constant 0.
        for (int i = 0; i < THERM_W-1; i++) begin
            bubble_o = bubble_o | (therm_i[i+1] & ~therm_i[i]);
        end
    end

endmodule

// File: rtl/ehgu_therm_decoder.sv
// rtl/ehgu_therm_decoder.sv - streaming thermometer-to-binary decoder with bubble repair and error count
// Purpose : two-stage pipeline; S1 registers the repaired code and bubble flag, S2 the decoded level.
// Ports   : clk, rst_n                    clock, async active-low reset
//           in_valid/in_ready/in_therm    thermometer input stream
//           out_valid/out_ready/out_bin/out_bubble  decoded output stream
//           clr_err                       synchronous clear of err_cnt/err_sat
//           err_cnt, err_sat              saturating bubble-word count and sticky saturation flag
module ehgu_therm_decoder
    import ehgu_basic_pkg::*;
#(
    parameter int BIN_W     = BINARY_OF_THERM_SIZE,
    parameter int THERM_W   = 2**BIN_W - 1,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [THERM_W-1:0]   in_therm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIN_W-1:0]     out_bin,
    output logic                 out_bubble,
    input  logic                 clr_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 err_sat
);

    logic                 s1_valid_q;
    logic [THERM_W-1:0]   s1_corr_q;
    logic                 s1_bubble_q;
    logic                 out_valid_q;
    logic [BIN_W-1:0]     out_bin_q;
    logic                 out_bubble_q;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 err_sat_q, err_sat_d;

    logic [THERM_W-1:0]   fix_corr;
    logic                 fix_bubble;
    logic [BIN_W-1:0]     enc_bin;
    logic                 s1_adv, s2_adv;
    logic                 count_evt;

    // Skid-free pipeline: each stage moves when its successor is empty or draining.
    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    ehgu_therm_bubble_fix #(
        .THERM_W (THERM_W)
    ) u_bubble_fix (
        .therm_i  (in_therm),
        .corr_o   (fix_corr),
        .bubble_o (fix_bubble)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_corr_q   <= '0;
            s1_bubble_q <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_corr_q   <= fix_corr;
                s1_bubble_q <= fix_bubble;
            end
        end
    end

    // Highest set bit wins, so multi-bit bubbles that survive repair still decode.
    always_comb begin
        enc_bin = '0;
        for (int i = 0; i < THERM_W; i++) begin
            if (s1_corr_q[i]) begin
                enc_bin = BIN_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_bin_q    <= '0;
            out_bubble_q <= 1'b0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_bin_q    <= enc_bin;
                out_bubble_q <= s1_bubble_q;
            end
        end
    end

    assign count_evt = out_valid_q && out_ready && out_bubble_q;

    // Clear has priority over a coincident counting handshake.
    always_comb begin
        err_cnt_d = err_cnt_q;
        err_sat_d = err_sat_q;
        if (clr_err) begin
            err_cnt_d = '0;
            err_sat_d = 1'b0;
        end else begin
            if (count_evt && !(&err_cnt_q)) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
            if (&err_cnt_d) begin
                err_sat_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
            err_sat_q <= 1'b0;
        end else begin
            err_cnt_q <= err_cnt_d;
            err_sat_q <= err_sat_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_bin    = out_bin_q;
    assign out_bubble = out_bubble_q;
    assign err_cnt    = err_cnt_q;
    assign err_sat    = err_sat_q;

endmodule

// File: tb/tb_ehgu_therm_decoder.sv
// tb/tb_ehgu_therm_decoder.sv - scoreboard bench for ehgu_therm_decoder
module tb_ehgu_therm_decoder;

    localparam int BIN_W     = 8;
    localparam int THERM_W   = 255;
    localparam int ERR_CNT_W = 2;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [THERM_W-1:0]   in_therm;
    logic                 out_valid;
    logic                 out_ready;
    logic [BIN_W-1:0]     out_bin;
    logic                 out_bubble;
    logic                 clr_err;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic                 err_sat;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int last_acc = 0;
    int nout   = 0;

    logic [8:0] sb[$];

    logic             prev_stall = 1'b0;
    logic [BIN_W-1:0] prev_bin   = '0;
    logic             prev_bub   = 1'b0;

    ehgu_therm_decoder #(
        .BIN_W     (BIN_W),
        .THERM_W   (THERM_W),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_therm   (in_therm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bin    (out_bin),
        .out_bubble (out_bubble),
        .clr_err    (clr_err),
        .err_cnt    (err_cnt),
        .err_sat    (err_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake; also checks hold-while-stalled.
    always @(negedge clk) begin
        logic [8:0] e;
        if (prev_stall && out_valid) begin
            check("stall_hold_bin", int'(out_bin), int'(prev_bin));
            check("stall_hold_bubble", int'(out_bubble), int'(prev_bub));
        end
        if (out_valid && out_ready) begin
            nout++;
            if (sb.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                e = sb.pop_front();
                check("out_bin", int'(out_bin), int'(e[7:0]));
                check("out_bubble", int'(out_bubble), int'(e[8]));
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_bin   = out_bin;
        prev_bub   = out_bubble;
    end

    function automatic logic [THERM_W-1:0] lvl(input int n);
        logic [THERM_W-1:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i] = 1'b1;
        return r;
    endfunction

    task automatic send(input logic [THERM_W-1:0] t, input logic [7:0] eb, input logic ebub);
        int n;
        bit done;
        n = 0;
        done = 0;
        in_valid = 1'b1;
        in_therm = t;
        while (!done && n < 50) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back({ebub, eb});
                last_acc = cyc;
                done = 1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) check("send_timeout", 1, 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_err();
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
    endtask

    initial begin
        logic [THERM_W-1:0] w;
        logic [THERM_W-1:0] words[4];
        logic [7:0]         lv[4];
        int idx, a0, a1, n, nsave;
        bit take;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_therm  = '0;
        out_ready = 1'b1;
        clr_err   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_err_cnt", int'(err_cnt), 0);
        check("rst_err_sat", int'(err_sat), 0);
        check("rst_out_bin", int'(out_bin), 0);

        // 1. clean word with latency check
        send(lvl(4), 8'd4, 1'b0);
        in_valid = 1'b0;
        check("lat_n1_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        check("lat_n2_out_valid", int'(out_valid), 1);
        drain();
        check("t1_err_cnt", int'(err_cnt), 0);

        // 2. single-bit bubbles
        w = lvl(10);
        w[5] = 1'b0;
        send(w, 8'd10, 1'b1);
        drain();
        check("t2a_err_cnt", int'(err_cnt), 1);
        w = lvl(4);
        w[20] = 1'b1;
        send(w, 8'd4, 1'b1);
        drain();
        check("t2b_err_cnt", int'(err_cnt), 2);

        // 3. extremes, back-to-back
        send('0, 8'd0, 1'b0);
        a0 = last_acc;
        send('1, 8'd255, 1'b0);
        a1 = last_acc;
        check("t3_back_to_back", a1 - a0, 1);
        drain();
        clear_err();
        check("clr_err_cnt", int'(err_cnt), 0);

        // 4. backpressure
        lv[0] = 8'd3;   lv[1] = 8'd7;   lv[2] = 8'd100; lv[3] = 8'd200;
        for (int i = 0; i < 4; i++) words[i] = lvl(int'(lv[i]));
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            take = 0;
            in_valid = (idx < 4);
            if (idx < 4) in_therm = words[idx];
            @(negedge clk);
            if (in_valid && in_ready) begin
                sb.push_back({1'b0, lv[idx]});
                take = 1;
            end
            @(posedge clk);
            #1;
            if (take) idx++;
        end
        check("t4_accepted", idx, 2);
        check("t4_in_ready_low", int'(in_ready), 0);
        check("t4_out_valid_held", int'(out_valid), 1);
        out_ready = 1'b1;
        send(words[2], lv[2], 1'b0);
        send(words[3], lv[3], 1'b0);
        drain();
        check("t4_sb_empty", sb.size(), 0);

        // 5. saturation with 2-bit counter
        w = lvl(10);
        w[5] = 1'b0;
        for (int i = 0; i < 5; i++) send(w, 8'd10, 1'b1);
        drain();
        check("t5_err_cnt_sat", int'(err_cnt), 3);
        check("t5_err_sat", int'(err_sat), 1);
        out_ready = 1'b0;
        send(w, 8'd10, 1'b1);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t5_out_valid_wait", int'(out_valid), 1);
        clr_err   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        check("t5_clr_wins_cnt", int'(err_cnt), 0);
        check("t5_clr_wins_sat", int'(err_sat), 0);
        drain();

        // 6. reset mid-stream
        send(w, 8'd10, 1'b1);
        drain();
        check("t6_err_cnt_pre", int'(err_cnt), 1);
        out_ready = 1'b0;
        send(lvl(9), 8'd9, 1'b0);
        send(lvl(11), 8'd11, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("t6_rst_out_valid", int'(out_valid), 0);
        check("t6_rst_err_cnt", int'(err_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("t6_in_ready", int'(in_ready), 1);
        nsave = nout;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("t6_no_stale", nout - nsave, 0);
        check("t6_out_valid", int'(out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
